// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: bus master in front of a 256x16 synchronous RAM.
//
// Arbitrates between a read-only instruction-fetch port and a read/write
// data port, sequences the RAM's registered read (buffer latched on one
// edge, driven under ram_oe in the following cycle) and owns the write-side
// drive of the bidirectional RAM data bus.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   fetch_req/fetch_addr        fetch request (held until fetch_ack)
//   fetch_ack/fetch_rdata       one-cycle completion pulse, last fetched word
//   data_req/data_we/data_addr/data_wdata
//                               data request (held until data_ack)
//   data_ack/data_rdata         one-cycle completion pulse, last read word
//   ram_st/ram_oe/ram_addr      registered RAM strobes and address
//   ram_data                    RAM data bus, driven only while ram_st=1
module ram_bus_ctrl #(
  parameter int BitCount  = 16,
  parameter int AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [AddrWidth-1:0] fetch_addr,
  output logic                 fetch_ack,
  output logic [BitCount-1:0]  fetch_rdata,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [AddrWidth-1:0] data_addr,
  input  logic [BitCount-1:0]  data_wdata,
  output logic                 data_ack,
  output logic [BitCount-1:0]  data_rdata,
  output logic                 ram_st,
  output logic                 ram_oe,
  output logic [AddrWidth-1:0] ram_addr,
  inout  wire  [BitCount-1:0]  ram_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RD_ACK  = 3'd4
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  state_t               state_r;
  logic                 last_grant_r;
  logic                 port_r;
  logic [BitCount-1:0]  wdata_r;

  logic                 grant_valid_s;
  logic                 grant_port_s;
  logic                 grant_write_s;
  logic [AddrWidth-1:0] grant_addr_s;

  // The bus is released unless a write is in flight; ram_st is a register,
  // so the drive enable never comes straight from a requester input.
  assign ram_data = ram_st ? wdata_r : {BitCount{1'bz}};

  // Round-robin arbitration between the two request ports.
  always_comb begin
    grant_valid_s = fetch_req | data_req;
    if (fetch_req && data_req) begin
      // On conflict the port that did not win last time goes next.
      grant_port_s = ~last_grant_r;
    end else if (data_req) begin
      grant_port_s = PORT_DATA;
    end else begin
      grant_port_s = PORT_FETCH;
    end
    grant_write_s = (grant_port_s == PORT_DATA) && data_we;
    grant_addr_s  = (grant_port_s == PORT_DATA) ? data_addr : fetch_addr;
  end

  // Transaction FSM with all RAM strobes and acks registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= PORT_FETCH;
      port_r       <= PORT_FETCH;
      wdata_r      <= {BitCount{1'b0}};
      ram_st       <= 1'b0;
      ram_oe       <= 1'b0;
      ram_addr     <= {AddrWidth{1'b0}};
      fetch_ack    <= 1'b0;
      data_ack     <= 1'b0;
      fetch_rdata  <= {BitCount{1'b0}};
      data_rdata   <= {BitCount{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
          ram_oe    <= 1'b0;
          if (grant_valid_s) begin
            ram_addr     <= grant_addr_s;
            port_r       <= grant_port_s;
            last_grant_r <= grant_port_s;
            wdata_r      <= data_wdata;
            if (grant_write_s) begin
              // Write completes in one cycle: strobe and ack together.
              state_r  <= WR;
              ram_st   <= 1'b1;
              data_ack <= 1'b1;
            end else begin
              state_r <= RD_ADDR;
              ram_st  <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            ram_st  <= 1'b0;
          end
        end
        WR: begin
          state_r   <= IDLE;
          ram_st    <= 1'b0;
          ram_oe    <= 1'b0;
          data_ack  <= 1'b0;
          fetch_ack <= 1'b0;
        end
        RD_ADDR: begin
          // RAM latches its read buffer on this edge; enable it next cycle.
          state_r <= RD_DATA;
          ram_st  <= 1'b0;
          ram_oe  <= 1'b1;
        end
        RD_DATA: begin
          state_r <= RD_ACK;
          ram_st  <= 1'b0;
          ram_oe  <= 1'b0;
          if (port_r == PORT_DATA) begin
            data_rdata <= ram_data;
            data_ack   <= 1'b1;
          end else begin
            fetch_rdata <= ram_data;
            fetch_ack   <= 1'b1;
          end
        end
        RD_ACK: begin
          state_r   <= IDLE;
          ram_st    <= 1'b0;
          ram_oe    <= 1'b0;
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          ram_st    <= 1'b0;
          ram_oe    <= 1'b0;
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
        end
      endcase
    end
  end

endmodule
